// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state encoding,
// datapath select encodings and the control-word layout.
package multicycle_control_unit_pkg;

    localparam int unsigned ALUOP_W_DEF = 2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [1:0] RES_ALU     = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_PC4     = 2'b10;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ir_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_instr;
    } ctrl_t;

    // Instruction class selected from DECODE; anything unrecognised traps.
    function automatic state_t decode_next(input logic [6:0] op, input bit en_jal);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXEC_R;
            OP_ITYPE:          return S_EXEC_I;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return en_jal ? S_JAL : S_TRAP;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Combinational state-to-control-word table for the multicycle control unit.
module multicycle_output_decode
    import multicycle_control_unit_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    // One control word per state; fields not listed stay zero.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a = SRCA_OLDPC;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.adr_src  = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_MEM;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_RS2;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_ALU;
            end
            S_BRANCH: begin
                o_ctrl.branch    = 1'b1;
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_RS2;
                o_ctrl.alu_op    = ALUOP_SUB;
            end
            S_JAL: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_PC4;
            end
            S_TRAP: begin
                o_ctrl.illegal_instr = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style multicycle control FSM: state/opcode registers and next-state logic;
// the per-state control word comes from multicycle_output_decode.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned ALUOP_W       = ALUOP_W_DEF,
    parameter bit          EN_JAL        = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               branch,
    output logic               ir_write,
    output logic               adr_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal_instr,
    output logic [3:0]         state_dbg
);

    state_t     r_state;
    logic [6:0] r_opcode;
    ctrl_t      w_ctrl;
    logic       w_mem_done;
    logic       w_fetch_ok;
    logic       w_unused_zero;

    // The PC update uses branch & zero in the datapath, so zero never steers the FSM.
    assign w_unused_zero = zero;
    assign w_mem_done    = (MEM_HANDSHAKE == 1'b0) || mem_ready;
    assign w_fetch_ok    = (r_state != S_FETCH) || w_mem_done;

    multicycle_output_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // State register, opcode latch and next-state selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_opcode <= 7'd0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= w_mem_done ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    r_opcode <= opcode;
                    r_state  <= decode_next(opcode, EN_JAL);
                end
                S_MEMADR: r_state <= (r_opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= w_mem_done ? S_MEMWB : S_MEMRD;
                S_MEMWR:  r_state <= w_mem_done ? S_FETCH : S_MEMWR;
                S_EXEC_R: r_state <= S_ALUWB;
                S_EXEC_I: r_state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_TRAP: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Reset forces every output quiet at once; fetch loads wait for mem_ready.
    assign pc_write      = rst_n & w_ctrl.pc_write & w_fetch_ok;
    assign ir_write      = rst_n & w_ctrl.ir_write & w_fetch_ok;
    assign branch        = rst_n & w_ctrl.branch;
    assign adr_src       = rst_n & w_ctrl.adr_src;
    assign mem_read      = rst_n & w_ctrl.mem_read;
    assign mem_write     = rst_n & w_ctrl.mem_write;
    assign reg_write     = rst_n & w_ctrl.reg_write;
    assign illegal_instr = rst_n & w_ctrl.illegal_instr;
    assign result_src    = rst_n ? w_ctrl.result_src : 2'b00;
    assign alu_src_a     = rst_n ? w_ctrl.alu_src_a : 2'b00;
    assign alu_src_b     = rst_n ? w_ctrl.alu_src_b : 2'b00;
    assign state_dbg     = r_state;

    // Zero-extend the two-bit ALU operation onto the configured width.
    always_comb begin
        alu_op = {ALUOP_W{1'b0}};
        if (rst_n) begin
            alu_op[1:0] = w_ctrl.alu_op;
        end else begin
            alu_op = {ALUOP_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (handshake+JAL+3-bit alu_op,
// and no-handshake without JAL) driven with random and directed instruction streams.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [6:0] a_opcode, b_opcode;
    logic       a_zero, b_zero, a_ready, b_ready;

    logic a_pc_write, a_branch, a_ir_write, a_adr_src, a_mem_read, a_mem_write, a_reg_write, a_illegal;
    logic b_pc_write, b_branch, b_ir_write, b_adr_src, b_mem_read, b_mem_write, b_reg_write, b_illegal;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b;
    logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b;
    logic [2:0] a_alu_op;
    logic [1:0] b_alu_op;
    logic [3:0] a_state, b_state;

    multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .ALUOP_W(3), .EN_JAL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(a_opcode), .zero(a_zero), .mem_ready(a_ready),
        .pc_write(a_pc_write), .branch(a_branch), .ir_write(a_ir_write), .adr_src(a_adr_src),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .reg_write(a_reg_write),
        .result_src(a_result_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_op(a_alu_op), .illegal_instr(a_illegal), .state_dbg(a_state)
    );

    multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .ALUOP_W(2), .EN_JAL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(b_opcode), .zero(b_zero), .mem_ready(b_ready),
        .pc_write(b_pc_write), .branch(b_branch), .ir_write(b_ir_write), .adr_src(b_adr_src),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .reg_write(b_reg_write),
        .result_src(b_result_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_op(b_alu_op), .illegal_instr(b_illegal), .state_dbg(b_state)
    );

    logic [16:0] vec_a, vec_b;
    assign vec_a = {a_pc_write, a_branch, a_ir_write, a_adr_src, a_mem_read, a_mem_write, a_reg_write,
                    a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_illegal};
    assign vec_b = {b_pc_write, b_branch, b_ir_write, b_adr_src, b_mem_read, b_mem_write, b_reg_write,
                    b_result_src, b_alu_src_a, b_alu_src_b, 1'b0, b_alu_op, b_illegal};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference outputs for one cycle, written straight from the per-state rules.
    function automatic logic [16:0] exp_vec(input state_t ph, input logic ready, input bit hs);
        logic pcw, br, irw, adr, mr, mw, rw, ill;
        logic [1:0] rs, sa, sb, op;
        {pcw, br, irw, adr, mr, mw, rw, ill} = 8'd0;
        {rs, sa, sb, op} = 8'd0;
        case (ph)
            S_FETCH:  begin mr = 1'b1; irw = hs ? ready : 1'b1; pcw = irw; sb = 2'b10; end
            S_DECODE: begin sa = 2'b01; sb = 2'b01; end
            S_MEMADR: begin sa = 2'b10; sb = 2'b01; end
            S_MEMRD:  begin mr = 1'b1; adr = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; rs = 2'b01; end
            S_MEMWR:  begin mw = 1'b1; adr = 1'b1; end
            S_EXEC_R: begin sa = 2'b10; sb = 2'b00; op = 2'b10; end
            S_EXEC_I: begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
            S_ALUWB:  begin rw = 1'b1; rs = 2'b00; end
            S_BRANCH: begin br = 1'b1; sa = 2'b10; sb = 2'b00; op = 2'b01; end
            S_JAL:    begin pcw = 1'b1; rw = 1'b1; rs = 2'b10; end
            S_TRAP:   begin ill = 1'b1; end
            default:  begin ill = 1'b0; end
        endcase
        return {pcw, br, irw, adr, mr, mw, rw, rs, sa, sb, 1'b0, op, ill};
    endfunction

    // One clock: drive at the falling edge, compare 1 ns later.
    task automatic cycle(input int which, input state_t ph, input logic [6:0] op,
                         input logic ready, input int zsel, input string tag);
        logic [6:0] o;
        logic z;
        @(negedge clk);
        o = (ph == S_DECODE) ? op : 7'($urandom);
        z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        if (which == 0) begin
            a_opcode = o; a_zero = z; a_ready = ready;
        end else begin
            b_opcode = o; b_zero = z; b_ready = ready;
        end
        #1;
        if (which == 0) begin
            chk({tag, " state"}, 32'(a_state), 32'(ph));
            chk({tag, " ctrl"}, 32'(vec_a), 32'(exp_vec(ph, ready, 1'b1)));
        end else begin
            chk({tag, " state"}, 32'(b_state), 32'(ph));
            chk({tag, " ctrl"}, 32'(vec_b), 32'(exp_vec(ph, ready, 1'b0)));
        end
    endtask

    // Walk one instruction through its expected phase list.
    task automatic run_instr(input int which, input logic [6:0] op, input int fixed_wait,
                             input int zsel, input string tag);
        state_t q[$];
        bit hs;
        int w;
        hs = (which == 0);
        q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        case (op)
            7'b0000011: begin q.push_back(S_MEMADR); q.push_back(S_MEMRD); q.push_back(S_MEMWB); end
            7'b0100011: begin q.push_back(S_MEMADR); q.push_back(S_MEMWR); end
            7'b0110011: begin q.push_back(S_EXEC_R); q.push_back(S_ALUWB); end
            7'b0010011: begin q.push_back(S_EXEC_I); q.push_back(S_ALUWB); end
            7'b1100011: q.push_back(S_BRANCH);
            7'b1101111: q.push_back((which == 0) ? S_JAL : S_TRAP);
            default:    q.push_back(S_TRAP);
        endcase
        foreach (q[i]) begin
            w = 0;
            if (hs && (q[i] == S_FETCH || q[i] == S_MEMRD || q[i] == S_MEMWR))
                w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            for (int k = 0; k < w; k++) cycle(which, q[i], op, 1'b0, zsel, tag);
            cycle(which, q[i], op, hs ? 1'b1 : 1'($urandom), zsel, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk({tag, " a_ctrl"}, 32'(vec_a), 32'd0);
            chk({tag, " a_state"}, 32'(a_state), 32'd0);
            chk({tag, " b_ctrl"}, 32'(vec_b), 32'd0);
            chk({tag, " b_state"}, 32'(b_state), 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic random_stream(input int which, input int n);
        logic [6:0] ops [7];
        logic [6:0] op;
        int idx;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};
        for (int i = 0; i < n; i++) begin
            idx = int'($urandom_range(0, 7));
            op = (idx == 7) ? 7'($urandom) : ops[idx];
            run_instr(which, op, -1, -1, "rand");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_opcode = 7'd0; a_zero = 1'b0; a_ready = 1'b0;
        b_opcode = 7'd0; b_zero = 1'b0; b_ready = 1'b0;
        do_reset("reset0");

        run_instr(0, 7'b0110011, 0, -1, "A_rtype");
        run_instr(0, 7'b0000011, 3, -1, "A_load_wait3");
        run_instr(0, 7'b0100011, -1, -1, "A_store");
        run_instr(0, 7'b0010011, -1, -1, "A_itype");
        run_instr(0, 7'b1100011, 0, 0, "A_branch_z0");
        run_instr(0, 7'b1100011, 0, 1, "A_branch_z1");
        run_instr(0, 7'b1101111, -1, -1, "A_jal");
        run_instr(0, 7'b1111111, -1, -1, "A_illegal");
        random_stream(0, 40);

        // Reset asserted while the store is in its write state.
        cycle(0, S_FETCH, 7'b0100011, 1'b1, -1, "A_rst_memwr");
        cycle(0, S_DECODE, 7'b0100011, 1'b1, -1, "A_rst_memwr");
        cycle(0, S_MEMADR, 7'b0100011, 1'b1, -1, "A_rst_memwr");
        @(negedge clk);
        a_ready = 1'b0;
        #1;
        chk("memwr state", 32'(a_state), 32'(S_MEMWR));
        chk("memwr mem_write", 32'(a_mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst mem_write", 32'(a_mem_write), 32'd0);
        chk("async rst state", 32'(a_state), 32'd0);
        chk("async rst ctrl", 32'(vec_a), 32'd0);
        do_reset("reset1");

        run_instr(1, 7'b0110011, -1, -1, "B_rtype");
        run_instr(1, 7'b0000011, -1, -1, "B_load");
        run_instr(1, 7'b0100011, -1, -1, "B_store");
        run_instr(1, 7'b1100011, -1, 0, "B_branch_z0");
        run_instr(1, 7'b1100011, -1, 1, "B_branch_z1");
        run_instr(1, 7'b1101111, -1, -1, "B_jal_disabled");
        run_instr(1, 7'b1111111, -1, -1, "B_illegal");
        random_stream(1, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
